// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default depth and bus widths.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned FQ_ADDR_W = 64;
  localparam int unsigned FQ_INST_W = 32;

endpackage

// File: rtl/fetch_queue_ptr.sv
// fq_ptr: wrapping pointer register with increment enable and synchronous clear.
//   clk, rst  : clock, async active-high reset (pointer -> 0)
//   clr_i     : return pointer to 0 on the next edge (has priority over inc_i)
//   inc_i     : advance pointer by one, wrapping modulo DEPTH
//   ptr_o     : current pointer value
module fq_ptr
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  // DEPTH is a power of two, so natural roll-over of the PTR_W-bit add is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between icache response and decode.
//   clk, rst                         : clock, async active-high reset
//   flush_i                          : branch redirect, drop all queued entries
//   resp_valid_i/resp_pc_i/resp_inst_i : icache response to enqueue
//   deq_ready_i                      : decode consumes the head entry
//   deq_valid_o/deq_pc_o/deq_inst_o  : head entry presented to decode
//   block_o                          : ask PC stage to hold (one slot of margin)
//   count_o                          : current occupancy
//   overflow_o                       : sticky, a response was dropped while full
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned ADDR_W = FQ_ADDR_W,
  parameter int unsigned INST_W = FQ_INST_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      resp_valid_i,
  input  logic [ADDR_W-1:0]         resp_pc_i,
  input  logic [INST_W-1:0]         resp_inst_i,
  input  logic                      deq_ready_i,
  output logic                      deq_valid_o,
  output logic [ADDR_W-1:0]         deq_pc_o,
  output logic [INST_W-1:0]         deq_inst_o,
  output logic                      block_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_d, count_q;
  logic             overflow_d, overflow_q;
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic full, deq_fire, enq_fire, drop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign deq_valid_o = (count_q != '0) & ~flush_i;
  assign deq_fire    = deq_valid_o & deq_ready_i;
  // A dequeue in the same cycle frees the slot, so a full queue still accepts.
  assign enq_fire    = resp_valid_i & ~flush_i & (~full | deq_fire);
  assign drop        = resp_valid_i & ~flush_i & full & ~deq_fire;

  fq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (deq_fire),
    .ptr_o (head)
  );

  fq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (enq_fire),
    .ptr_o (tail)
  );

  // Occupancy, sticky overflow and storage write (flush does not clear data).
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    mem_d      = mem_q;
    if (flush_i) begin
      count_d = '0;
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CNT_W'(1);
    end
    if (enq_fire) begin
      mem_d[tail] = {resp_pc_i, resp_inst_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign deq_pc_o   = mem_q[head][ENT_W-1 -: ADDR_W];
  assign deq_inst_o = mem_q[head][INST_W-1:0];
  assign block_o    = (count_q >= CNT_W'(DEPTH - 1)) & ~flush_i;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
